mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//  Sequencer for one signed 16x16 MAC with a 32-bit accumulator. Given a dot-product
//  job (length, activation base/stride, weight base), it clears the accumulator, streams
//  operand reads from the activation and weight SRAMs, and gates mac_enable to match SRAM
//  read latency. It then drains the multiplier pipeline and returns the 32-bit sum over a
//  valid/ready handshake. Sits between the layer scheduler and the MAC datapath.
// PARAMETERS
//  ADDR_W   10  SRAM address width; address arithmetic wraps modulo 2^ADDR_W
//  LEN_W    8   job length field width (max len = 2^LEN_W-1)
//  PIPE_LAT 4   edges from MAC operand-sampling edge to product included in mac_acc
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  reset        in   1       reset, asynchronous, active-high
//  start        in   1       job request; sampled only in IDLE
//  len          in   LEN_W   number of products in job (0 allowed)
//  in_base      in   ADDR_W  first activation address
//  in_stride    in   ADDR_W  activation address increment per product
//  w_base       in   ADDR_W  first weight address (weight increment fixed at 1)
//  busy         out  1       high in every state except IDLE
//  done         out  1       1-cycle pulse when result handshake completes
//  in_rd_en     out  1       activation SRAM read strobe (data returns next cycle)
//  in_rd_addr   out  ADDR_W  activation SRAM read address
//  w_rd_en      out  1       weight SRAM read strobe (data returns next cycle)
//  w_rd_addr    out  ADDR_W  weight SRAM read address
//  mac_enable   out  1       MAC operand-capture enable
//  mac_clear    out  1       MAC accumulator synchronous clear
//  mac_acc      in   32      MAC accumulator value
//  result       out  32      captured dot product (signed)
//  result_valid out  1       result available; held until result_ready
//  result_ready in   1       consumer accepts result
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, rd_en's, mac_enable, mac_clear, result_valid = 0;
//    addresses = 0; result = 0. Reset mid-job aborts immediately; no done pulse.
//  - All outputs registered. FSM states: IDLE, CLEAR, ISSUE, DRAIN, RESULT.
//  - IDLE: on start=1, latch len/in_base/in_stride/w_base -> CLEAR. start ignored elsewhere.
//  - CLEAR (1 cycle): mac_clear=1. -> ISSUE if len!=0, else -> DRAIN.
//  - ISSUE (len cycles): cycle i drives in_rd_en=w_rd_en=1,
//    in_rd_addr=in_base+i*in_stride, w_rd_addr=w_base+i (mod 2^ADDR_W). After cycle
//    len-1 -> DRAIN.
//  - mac_enable = read strobe delayed exactly 1 cycle, so it is high in the cycle SRAM
//    data is valid; low at all other times (MAC then adds zero products).
//  - DRAIN: exactly PIPE_LAT+1 cycles, counted from the cycle after the last ISSUE cycle
//    (or after CLEAR when len=0). At the edge ending DRAIN: result<=mac_acc,
//    result_valid<=1 -> RESULT.
//  - RESULT: hold result/result_valid until result_ready=1. On the accepting edge:
//    result_valid<=0, done pulses in the next cycle, -> IDLE. result holds its value
//    until the next capture.
//  - len=0 returns result=0. Back-to-back jobs: the earliest start is in the cycle after
//    done. mac_clear is asserted only in CLEAR.
//  - Counters: product index LEN_W bits; DRAIN counter sized for PIPE_LAT+1.
// TESTING
//  1. len=3, in_base=0x10, stride=2, w_base=0x40; act=2,-3,5, wt=7,4,-1
//     -> in addrs 0x10,0x12,0x14; w addrs 0x40..0x42; result=0xFFFFFFFD (-3); one done.
//  2. len=0 with start -> CLEAR, PIPE_LAT+1 DRAIN cycles, result=0, no rd_en asserted.
//  3. Hold result_ready=0 for 5 cycles in RESULT -> result_valid and result stable;
//     done exactly 1 cycle after ready=1.
//  4. Pulse start during ISSUE of a len=4 job -> ignored; exactly 4 reads, one done.
//  5. in_base=0x3FE, stride=1, len=4 (ADDR_W=10) -> in_rd_addr 0x3FE,0x3FF,0x000,0x001.
//  6. Assert reset in the 2nd ISSUE cycle -> all outputs 0 at once. A new len=2 job
//     then yields the correct sum unpolluted by the aborted job (CLEAR precedes it).

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Sequences one dot-product job for a signed 16x16 MAC: clear, issue len SRAM reads, drain PIPE_LAT+1 cycles.
// All outputs registered; the result waits in RESULT until the consumer takes it (valid/ready), then done pulses.
module mac_seq_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [ADDR_W-1:0] in_base_i,
    input  logic [ADDR_W-1:0] in_stride_i,
    input  logic [ADDR_W-1:0] w_base_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              in_rd_en_o,
    output logic [ADDR_W-1:0] in_rd_addr_o,
    output logic              w_rd_en_o,
    output logic [ADDR_W-1:0] w_rd_addr_o,
    output logic              mac_enable_o,
    output logic              mac_clear_o,
    input  logic [31:0]       mac_acc_i,
    output logic [31:0]       result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i
);
    localparam int DW = $clog2(PIPE_LAT + 2);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_RESULT} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
    logic [ADDR_W-1:0] stride_q, stride_d, in_addr_q, in_addr_d, w_addr_q, w_addr_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              rd_en_q, rd_en_d, mac_en_q, mac_en_d, clear_q, clear_d;
    logic              done_q, done_d, busy_q, busy_d, valid_q, valid_d;
    logic [31:0]       result_q, result_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            stride_q  <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
            drain_q   <= '0;
            rd_en_q   <= 1'b0;
            mac_en_q  <= 1'b0;
            clear_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            stride_q  <= stride_d;
            in_addr_q <= in_addr_d;
            w_addr_q  <= w_addr_d;
            drain_q   <= drain_d;
            rd_en_q   <= rd_en_d;
            mac_en_q  <= mac_en_d;
            clear_q   <= clear_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        stride_d  = stride_q;
        in_addr_d = in_addr_q;
        w_addr_d  = w_addr_q;
        drain_d   = drain_q;
        rd_en_d   = 1'b0;
        // SRAM data lands one cycle after the strobe, so the MAC captures then.
        mac_en_d  = rd_en_q;
        clear_d   = 1'b0;
        done_d    = 1'b0;
        valid_d   = valid_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d     = len_i;
                    stride_d  = in_stride_i;
                    in_addr_d = in_base_i;
                    w_addr_d  = w_base_i;
                    clear_d   = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                idx_d   = '0;
                drain_d = '0;
                if (len_q != '0) begin
                    rd_en_d = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_ISSUE: begin
                // Registered addresses show read idx_q now; advance them for the next read.
                in_addr_d = in_addr_q + stride_q;
                w_addr_d  = w_addr_q + ADDR_W'(1);
                idx_d     = idx_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(PIPE_LAT)) begin
                    result_d = (len_q == '0) ? 32'd0 : mac_acc_i;
                    valid_d  = 1'b1;
                    state_d  = S_RESULT;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_RESULT: begin
                if (result_ready_i) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign in_rd_en_o     = rd_en_q;
    assign w_rd_en_o      = rd_en_q;
    assign in_rd_addr_o   = in_addr_q;
    assign w_rd_addr_o    = w_addr_q;
    assign mac_enable_o   = mac_en_q;
    assign mac_clear_o    = clear_q;
    assign result_o       = result_q;
    assign result_valid_o = valid_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural SRAMs and MAC around the sequencer, expected sums and
// address streams computed directly from the job description.
module tb_mac_seq_ctrl;
    localparam int PIPE_LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  len_i = '0;
    logic [9:0]  in_base_i = '0, in_stride_i = '0, w_base_i = '0;
    logic        busy_o, done_o, in_rd_en_o, w_rd_en_o, mac_enable_o, mac_clear_o;
    logic [9:0]  in_rd_addr_o, w_rd_addr_o;
    logic [31:0] mac_acc = '0;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.ADDR_W(10), .LEN_W(8), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .len_i(len_i),
        .in_base_i(in_base_i), .in_stride_i(in_stride_i), .w_base_i(w_base_i),
        .busy_o(busy_o), .done_o(done_o),
        .in_rd_en_o(in_rd_en_o), .in_rd_addr_o(in_rd_addr_o),
        .w_rd_en_o(w_rd_en_o), .w_rd_addr_o(w_rd_addr_o),
        .mac_enable_o(mac_enable_o), .mac_clear_o(mac_clear_o),
        .mac_acc_i(mac_acc), .result_o(result_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i)
    );

    // Environment: SRAMs with one-cycle read latency and a MAC whose product reaches the
    // accumulator PIPE_LAT edges after capture. Not reset, so stale sums survive an abort.
    logic signed [15:0] act_mem [1024];
    logic signed [15:0] wt_mem  [1024];
    logic signed [15:0] act_dq = '0, wt_dq = '0;
    logic signed [31:0] p0 = '0, p1 = '0, p2 = '0;

    always @(posedge clk) begin
        if (in_rd_en_o) act_dq <= act_mem[in_rd_addr_o];
        if (w_rd_en_o)  wt_dq  <= wt_mem[w_rd_addr_o];
        if (mac_clear_o) begin
            p0 <= '0; p1 <= '0; p2 <= '0; mac_acc <= '0;
        end else begin
            p0 <= mac_enable_o ? int'(act_dq) * int'(wt_dq) : 0;
            p1 <= p0;
            p2 <= p1;
            mac_acc <= mac_acc + p2;
        end
    end

    logic [9:0] in_q[$], w_q[$];
    int done_cnt, clr_cnt, en_cnt, en_err;
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        if (in_rd_en_o) in_q.push_back(in_rd_addr_o);
        if (w_rd_en_o)  w_q.push_back(w_rd_addr_o);
        if (done_o)      done_cnt++;
        if (mac_clear_o) clr_cnt++;
        if (mac_enable_o) en_cnt++;
        if (mac_enable_o !== prev_rd) en_err++;
        prev_rd = in_rd_en_o;
    end

    int ntotal = 0, npass = 0, nfail = 0;
    logic [31:0] last_result;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_in_addr(int ib, int st, int i);
        return (ib + i * st) % 1024;
    endfunction

    function automatic logic [31:0] model_sum(int n, int ib, int st, int wb);
        int s = 0;
        for (int i = 0; i < n; i++)
            s += int'(act_mem[model_in_addr(ib, st, i)]) * int'(wt_mem[(wb + i) % 1024]);
        return s;
    endfunction

    task automatic run_job(input int n, input logic [9:0] ib, input logic [9:0] st,
                           input logic [9:0] wb, input int hold, input bit poke);
        int lat, stab_err;
        logic [31:0] exp_sum, res0;
        exp_sum = model_sum(n, ib, st, wb);
        in_q.delete(); w_q.delete();
        done_cnt = 0; clr_cnt = 0; en_cnt = 0; en_err = 0;
        @(negedge clk);
        start_i = 1'b1; len_i = 8'(n); in_base_i = ib; in_stride_i = st; w_base_i = wb;
        @(negedge clk);
        start_i = 1'b0;
        chk("clear_cycle", {63'd0, mac_clear_o}, 64'd1);
        lat = 1;
        while (result_valid_o !== 1'b1 && lat < 400) begin
            // A stray start during the first ISSUE cycles must be ignored.
            start_i = poke && (lat == 2 || lat == 3);
            len_i   = 8'hFF;
            @(negedge clk);
            lat++;
        end
        start_i = 1'b0;
        chk("valid_seen", {63'd0, result_valid_o}, 64'd1);
        chk("latency", 64'(lat), 64'(n + PIPE_LAT + 3));
        chk("result", 64'(result_o), 64'(exp_sum));
        res0 = result_o;
        stab_err = 0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (result_o !== res0 || result_valid_o !== 1'b1 || done_o !== 1'b0) stab_err++;
        end
        chk("hold_stable", 64'(stab_err), 64'd0);
        result_ready_i = 1'b1;
        @(negedge clk);
        result_ready_i = 1'b0;
        chk("done_pulse", {63'd0, done_o}, 64'd1);
        chk("valid_drop", {63'd0, result_valid_o}, 64'd0);
        chk("busy_drop", {63'd0, busy_o}, 64'd0);
        chk("result_held", 64'(result_o), 64'(exp_sum));
        @(negedge clk);
        chk("done_once", {63'd0, done_o}, 64'd0);
        #1;
        chk("in_reads", 64'(in_q.size()), 64'(n));
        chk("w_reads", 64'(w_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk("in_addr", (i < in_q.size()) ? 64'(in_q[i]) : {64{1'bx}}, 64'(model_in_addr(ib, st, i)));
            chk("w_addr", (i < w_q.size()) ? 64'(w_q[i]) : {64{1'bx}}, 64'((wb + i) % 1024));
        end
        chk("clear_count", 64'(clr_cnt), 64'd1);
        chk("enable_count", 64'(en_cnt), 64'(n));
        chk("enable_align", 64'(en_err), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd1);
        last_result = result_o;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            act_mem[a] = 16'($urandom);
            wt_mem[a]  = 16'($urandom);
        end
        act_mem[10'h010] = 16'sd2;  act_mem[10'h012] = -16'sd3; act_mem[10'h014] = 16'sd5;
        wt_mem[10'h040]  = 16'sd7;  wt_mem[10'h041]  = 16'sd4;  wt_mem[10'h042]  = -16'sd1;

        #1;
        chk("reset_outs", {busy_o, done_o, in_rd_en_o, w_rd_en_o, mac_enable_o, mac_clear_o,
                           result_valid_o, in_rd_addr_o, w_rd_addr_o, result_o}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", {63'd0, busy_o}, 64'd0);

        run_job(3, 10'h010, 10'd2, 10'h040, 0, 1'b0);
        chk("dot3_value", 64'(last_result), 64'h0000_0000_FFFF_FFFD);

        run_job(0, 10'h123, 10'd5, 10'h200, 1, 1'b0);
        chk("len0_value", 64'(last_result), 64'd0);

        run_job(5, 10'($urandom), 10'($urandom), 10'($urandom), 5, 1'b0);
        run_job(4, 10'h080, 10'd3, 10'h300, 0, 1'b1);
        run_job(4, 10'h3FE, 10'd1, 10'h3FF, 2, 1'b0);

        for (int j = 0; j < 5; j++)
            run_job(int'($urandom_range(1, 16)), 10'($urandom), 10'($urandom), 10'($urandom),
                    int'($urandom_range(0, 3)), 1'b0);
        run_job(255, 10'($urandom), 10'($urandom), 10'($urandom), 1, 1'b0);

        // Abort in the second ISSUE cycle, then check a fresh job is unaffected.
        @(negedge clk);
        start_i = 1'b1; len_i = 8'd4; in_base_i = 10'h050; in_stride_i = 10'd1; w_base_i = 10'h060;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_issue", {62'd0, busy_o, in_rd_en_o}, 64'd3);
        reset = 1'b1;
        #1;
        chk("abort_outs", {busy_o, done_o, in_rd_en_o, w_rd_en_o, mac_enable_o, mac_clear_o,
                           result_valid_o, in_rd_addr_o, w_rd_addr_o, result_o}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        run_job(2, 10'h070, 10'd7, 10'h090, 1, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
